comparator_4bit: RTL and testbench

COMPARATOR_4BIT -- requirements
Module: comparator_4bit

---
 rtl/comparator_4bit_pkg.sv | 23 ++
 rtl/comparator_1bit.sv | 13 +
 rtl/comparator_4bit.sv | 65 ++++++
 tb/tb_comparator_4bit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_4bit_pkg.sv
// Shared definitions for the cascadable 4-bit magnitude comparator:
// default operand width and the one-hot {Equal, Greater, Less} result encodings.
package comparator_4bit_pkg;

  localparam int WidthDefault = 4;

  typedef enum logic [2:0] {
    ResRst = 3'b000,
    ResLt  = 3'b001,
    ResGt  = 3'b010,
    ResEq  = 3'b100
  } cmpResult_e;

  // Lower-stage verdict used when the local operands tie; an all-zero cascade reads as equal.
  function automatic cmpResult_e resolveCascade(input logic eqIn, input logic gtIn,
                                                input logic ltIn);
    if (eqIn)      return ResEq;
    else if (gtIn) return ResGt;
    else if (ltIn) return ResLt;
    else           return ResEq;
  endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Single bit slice of the magnitude comparator: flags whether this bit alone
// makes A greater or less than B.
module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/comparator_4bit.sv
// Cascadable unsigned 4-bit magnitude comparator with a registered one-hot
// {Equal, Greater, Less} result and one cycle of latency.
module comparator_4bit
  import comparator_4bit_pkg::*;
#(
  parameter int WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             EqualIn,
  input  logic             GreaterIn,
  input  logic             LessIn,
  output logic             EqualOut,
  output logic             GreaterOut,
  output logic             LessOut
);

  logic [WIDTH-1:0] bitGt;
  logic [WIDTH-1:0] bitLt;
  logic             magGt;
  logic             magLt;
  cmpResult_e       nextResult;
  cmpResult_e       result_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : gSlice
    comparator_1bit uSlice (
      .a  (A[i]),
      .b  (B[i]),
      .gt (bitGt[i]),
      .lt (bitLt[i])
    );
  end

  // Scanning upward lets each higher differing bit override the lower ones,
  // so the most significant difference decides.
  always_comb begin
    magGt = 1'b0;
    magLt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bitGt[i] || bitLt[i]) begin
        magGt = bitGt[i];
        magLt = bitLt[i];
      end
    end
  end

  always_comb begin
    nextResult = ResRst;
    if (magGt)      nextResult = ResGt;
    else if (magLt) nextResult = ResLt;
    else            nextResult = resolveCascade(EqualIn, GreaterIn, LessIn);
  end

  // Stage p0: output register. Reset clears it at once; release only takes
  // effect at the next rising clk edge, which loads a fresh comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_p0 <= ResRst;
    else        result_p0 <= nextResult;
  end

  assign {EqualOut, GreaterOut, LessOut} = result_p0;

endmodule

// File: tb/tb_comparator_4bit.sv
// Self-checking bench for comparator_4bit: directed scenarios, exhaustive and
// random sweeps against a reference model, plus a continuous one-hot monitor.
module tb_comparator_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic       EqualIn = 1'b1;
  logic       GreaterIn = 1'b0;
  logic       LessIn = 1'b0;
  logic       EqualOut;
  logic       GreaterOut;
  logic       LessOut;

  int tests = 0;
  int fails = 0;
  logic armed = 1'b0;

  comparator_4bit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .EqualIn    (EqualIn),
    .GreaterIn  (GreaterIn),
    .LessIn     (LessIn),
    .EqualOut   (EqualOut),
    .GreaterOut (GreaterOut),
    .LessOut    (LessOut)
  );

  always #5 clk = ~clk;

  // Expected {Equal, Greater, Less} straight from the comparison rules.
  function automatic logic [2:0] refModel(input int a, input int b, input logic [2:0] casc);
    if (a > b) return 3'b010;
    if (a < b) return 3'b001;
    if (casc[2]) return 3'b100;
    if (casc[1]) return 3'b010;
    if (casc[0]) return 3'b001;
    return 3'b100;
  endfunction

  // Outputs are only meaningful once an edge has loaded them after reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && armed) begin
      tests++;
      if ($countones({EqualOut, GreaterOut, LessOut}) != 1) begin
        fails++;
        $display("FAIL onehot t=%0t got=%b required exactly one bit set", $time,
                 {EqualOut, GreaterOut, LessOut});
      end
    end
  end

  // Present operands, let one rising edge capture them, settle 1 time unit.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] casc);
    A = a;
    B = b;
    {EqualIn, GreaterIn, LessIn} = casc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'd15, 4'd0, 3'b100);
    drive(4'd3, 4'd3, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b000) begin
      fails++;
      $display("FAIL reset_async got=%b required=000", {EqualOut, GreaterOut, LessOut});
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b000) begin
      fails++;
      $display("FAIL reset_hold got=%b required=000", {EqualOut, GreaterOut, LessOut});
    end
    A = 4'd0;
    B = 4'd0;
    {EqualIn, GreaterIn, LessIn} = 3'b100;
    rst_n = 1'b1;
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release_pre_edge got=%b required=000", {EqualOut, GreaterOut, LessOut});
    end
    @(posedge clk);
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b100) begin
      fails++;
      $display("FAIL reset_first_load got=%b required=100", {EqualOut, GreaterOut, LessOut});
    end
  endtask

  task automatic test_magnitude();
    drive(4'b0100, 4'b0010, 3'b100);
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b010) begin
      fails++;
      $display("FAIL mag_gt got=%b required=010", {EqualOut, GreaterOut, LessOut});
    end
    drive(4'b0010, 4'b0100, 3'b100);
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b001) begin
      fails++;
      $display("FAIL mag_lt got=%b required=001", {EqualOut, GreaterOut, LessOut});
    end
  endtask

  task automatic test_cascade();
    logic [2:0] cascTab [4] = '{3'b010, 3'b001, 3'b000, 3'b111};
    logic [2:0] expTab  [4] = '{3'b010, 3'b001, 3'b100, 3'b100};
    for (int i = 0; i < 4; i++) begin
      drive(4'b1001, 4'b1001, cascTab[i]);
      tests++;
      if ({EqualOut, GreaterOut, LessOut} !== expTab[i]) begin
        fails++;
        $display("FAIL cascade casc=%b got=%b required=%b", cascTab[i],
                 {EqualOut, GreaterOut, LessOut}, expTab[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] aTab [5] = '{4'b1111, 4'b1000, 4'b0000, 4'b1111, 4'b1111};
    logic [3:0] bTab [5] = '{4'b0000, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    logic [2:0] cTab [5] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b011};
    logic [2:0] eTab [5] = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010};
    for (int i = 0; i < 5; i++) begin
      drive(aTab[i], bTab[i], cTab[i]);
      tests++;
      if ({EqualOut, GreaterOut, LessOut} !== eTab[i]) begin
        fails++;
        $display("FAIL boundary A=%b B=%b casc=%b got=%b required=%b", aTab[i], bTab[i],
                 cTab[i], {EqualOut, GreaterOut, LessOut}, eTab[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [2:0] expv;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 8; c++) begin
          drive(4'(a), 4'(b), 3'(c));
          expv = refModel(a, b, 3'(c));
          tests++;
          if ({EqualOut, GreaterOut, LessOut} !== expv) begin
            fails++;
            $display("FAIL exhaustive A=%0d B=%0d casc=%b got=%b required=%b", a, b, 3'(c),
                     {EqualOut, GreaterOut, LessOut}, expv);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int         a;
    int         b;
    logic [2:0] c;
    logic [2:0] expv;
    for (int n = 0; n < 300; n++) begin
      a = int'($urandom_range(15, 0));
      b = ($urandom_range(3, 0) == 0) ? a : int'($urandom_range(15, 0));
      c = 3'($urandom_range(7, 0));
      drive(4'(a), 4'(b), c);
      expv = refModel(a, b, c);
      tests++;
      if ({EqualOut, GreaterOut, LessOut} !== expv) begin
        fails++;
        $display("FAIL random A=%0d B=%0d casc=%b got=%b required=%b", a, b, c,
                 {EqualOut, GreaterOut, LessOut}, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd9, 4'd2, 3'b100);
    drive(4'd2, 4'd9, 3'b100);
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b001) begin
      fails++;
      $display("FAIL b2b_pre got=%b required=001", {EqualOut, GreaterOut, LessOut});
    end
    // A Greater result is pending when reset lands between edges.
    A = 4'd12;
    B = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b000) begin
      fails++;
      $display("FAIL b2b_reset_immediate got=%b required=000", {EqualOut, GreaterOut, LessOut});
    end
    @(posedge clk);
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b000) begin
      fails++;
      $display("FAIL b2b_pending_lost got=%b required=000", {EqualOut, GreaterOut, LessOut});
    end
    A = 4'd4;
    B = 4'd4;
    {EqualIn, GreaterIn, LessIn} = 3'b001;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({EqualOut, GreaterOut, LessOut} !== 3'b001) begin
      fails++;
      $display("FAIL b2b_after_release got=%b required=001", {EqualOut, GreaterOut, LessOut});
    end
  endtask

  initial begin
    test_reset();
    test_magnitude();
    test_cascade();
    test_boundaries();
    test_exhaustive();
    test_random();
    test_back_to_back();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
